// File: rtl/ddr_sdram_bank_sched.sv
// SDRAM command scheduler: power-up init, per-bank open-row tracking, periodic
// refresh and one outstanding read/write. All command pins are registered.
module ddr_sdram_bank_sched #(
  parameter int ROW_W   = 12,
  parameter int COL_W   = 9,
  parameter int BANK_W  = 2,
  parameter int T_INIT  = 200,
  parameter int T_RP    = 3,
  parameter int T_RCD   = 3,
  parameter int T_RFC   = 10,
  parameter int T_GAP   = 4,
  parameter int CL      = 3,
  parameter int REF_INT = 780,
  parameter logic [ROW_W-1:0] MODE_REG = 12'h033
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          REQ_VALID,
  output logic                          REQ_READY,
  input  logic                          REQ_WR,
  input  logic [BANK_W+ROW_W+COL_W-1:0] REQ_ADDR,
  output logic [ROW_W-1:0]              SA,
  output logic [BANK_W-1:0]             BA,
  output logic                          CS_N,
  output logic                          RAS_N,
  output logic                          CAS_N,
  output logic                          WE_N,
  output logic                          CKE,
  output logic                          WR_STB,
  output logic                          RD_STB,
  output logic                          INIT_DONE
);

  localparam int NB    = 1 << BANK_W;
  localparam int CNT_W = 16;
  localparam int REF_W = $clog2(REF_INT);

  localparam logic [3:0] S_INIT_WAIT = 4'd0,  S_INIT_PRE = 4'd1, S_INIT_REF1 = 4'd2,
                         S_INIT_REF2 = 4'd3,  S_INIT_LMR = 4'd4, S_IDLE      = 4'd5,
                         S_PRE       = 4'd6,  S_ACT      = 4'd7, S_RW        = 4'd8,
                         S_GAP       = 4'd9,  S_REF_PRE  = 4'd10, S_REF      = 4'd11;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP = 4'b1111, CMD_ACT = 4'b0011, CMD_READ = 4'b0101,
                         CMD_WRITE = 4'b0100, CMD_PRE = 4'b0010, CMD_REF = 4'b0001,
                         CMD_LMR = 4'b0000;

  localparam logic [ROW_W-1:0] SA_ALL = ROW_W'(1'b1) << 10;

  logic [3:0]        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              cnt_zero_s;
  logic [3:0]        cmd_r, cmd_s;
  logic [ROW_W-1:0]  sa_r, sa_s;
  logic [BANK_W-1:0] ba_r, ba_s;
  logic              cke_r, ready_r, ready_s, init_done_r, init_done_s, wr_stb_r;
  logic              pend_r, pend_s, pend_clr_s, ref_term_s;
  logic [REF_W-1:0]  ref_cnt_r;
  logic [CL-1:0]     rd_pipe_r;
  logic [NB-1:0]     valid_r;
  logic [ROW_W-1:0]  open_row_r [NB];
  logic              tbl_set_s, tbl_clr_s, tbl_clr_all_s, accept_s;
  logic [BANK_W-1:0] tbl_bank_s, bank_r, req_bank_s;
  logic [ROW_W-1:0]  tbl_row_s, row_r, req_row_s;
  logic [COL_W-1:0]  col_r, req_col_s;
  logic              wr_r;

  function automatic logic [3:0] rw_cmd(input logic wr);
    return wr ? CMD_WRITE : CMD_READ;
  endfunction

  assign req_bank_s = REQ_ADDR[BANK_W+ROW_W+COL_W-1 -: BANK_W];
  assign req_row_s  = REQ_ADDR[ROW_W+COL_W-1 -: ROW_W];
  assign req_col_s  = REQ_ADDR[COL_W-1:0];
  assign cnt_zero_s = (cnt_r == '0);
  assign ref_term_s = init_done_r && (ref_cnt_r == REF_W'(REF_INT - 1));

  // Next state, next command and open-row table updates
  always_comb begin
    state_s = state_r;  cnt_s = cnt_r;  cmd_s = CMD_NOP;  sa_s = '0;  ba_s = '0;
    accept_s = 1'b0;  tbl_set_s = 1'b0;  tbl_clr_s = 1'b0;  tbl_clr_all_s = 1'b0;
    tbl_bank_s = bank_r;  tbl_row_s = row_r;  pend_clr_s = 1'b0;
    case (state_r)
      S_INIT_WAIT:
        if (cnt_zero_s) begin
          state_s = S_INIT_PRE;  cmd_s = CMD_PRE;  sa_s = SA_ALL;  cnt_s = CNT_W'(T_RP - 1);
        end else cnt_s = cnt_r - CNT_W'(1);
      S_INIT_PRE:
        if (cnt_zero_s) begin
          state_s = S_INIT_REF1;  cmd_s = CMD_REF;  cnt_s = CNT_W'(T_RFC - 1);
        end else cnt_s = cnt_r - CNT_W'(1);
      S_INIT_REF1:
        if (cnt_zero_s) begin
          state_s = S_INIT_REF2;  cmd_s = CMD_REF;  cnt_s = CNT_W'(T_RFC - 1);
        end else cnt_s = cnt_r - CNT_W'(1);
      S_INIT_REF2:
        if (cnt_zero_s) begin
          state_s = S_INIT_LMR;  cmd_s = CMD_LMR;  sa_s = MODE_REG;  cnt_s = CNT_W'(1);
        end else cnt_s = cnt_r - CNT_W'(1);
      S_INIT_LMR:
        if (cnt_zero_s) state_s = S_IDLE;
        else cnt_s = cnt_r - CNT_W'(1);
      S_IDLE:
        // Refresh wins over a request arriving in the same cycle
        if (pend_r) begin
          if (|valid_r) begin
            state_s = S_REF_PRE;  cmd_s = CMD_PRE;  sa_s = SA_ALL;  cnt_s = CNT_W'(T_RP - 1);
          end else begin
            state_s = S_REF;  cmd_s = CMD_REF;  cnt_s = CNT_W'(T_RFC - 1);
          end
        end else if (REQ_VALID && ready_r) begin
          accept_s = 1'b1;  tbl_bank_s = req_bank_s;  tbl_row_s = req_row_s;  ba_s = req_bank_s;
          if (valid_r[req_bank_s] && open_row_r[req_bank_s] == req_row_s) begin
            state_s = S_RW;  cmd_s = rw_cmd(REQ_WR);  sa_s = ROW_W'(req_col_s);
            cnt_s = CNT_W'(T_GAP - 1);
          end else if (valid_r[req_bank_s]) begin
            state_s = S_PRE;  cmd_s = CMD_PRE;  tbl_clr_s = 1'b1;  cnt_s = CNT_W'(T_RP - 1);
          end else begin
            state_s = S_ACT;  cmd_s = CMD_ACT;  sa_s = req_row_s;  tbl_set_s = 1'b1;
            cnt_s = CNT_W'(T_RCD - 1);
          end
        end else state_s = S_IDLE;
      S_PRE:
        if (cnt_zero_s) begin
          state_s = S_ACT;  cmd_s = CMD_ACT;  ba_s = bank_r;  sa_s = row_r;  tbl_set_s = 1'b1;
          cnt_s = CNT_W'(T_RCD - 1);
        end else cnt_s = cnt_r - CNT_W'(1);
      S_ACT:
        if (cnt_zero_s) begin
          state_s = S_RW;  cmd_s = rw_cmd(wr_r);  ba_s = bank_r;  sa_s = ROW_W'(col_r);
          cnt_s = CNT_W'(T_GAP - 1);
        end else cnt_s = cnt_r - CNT_W'(1);
      S_RW: begin
        state_s = S_GAP;  cnt_s = cnt_r - CNT_W'(1);
      end
      S_GAP:
        if (cnt_zero_s) state_s = S_IDLE;
        else cnt_s = cnt_r - CNT_W'(1);
      S_REF_PRE:
        if (cnt_zero_s) begin
          state_s = S_REF;  cmd_s = CMD_REF;  cnt_s = CNT_W'(T_RFC - 1);
        end else cnt_s = cnt_r - CNT_W'(1);
      S_REF:
        if (cnt_zero_s) begin
          state_s = S_IDLE;  tbl_clr_all_s = 1'b1;  pend_clr_s = 1'b1;
        end else cnt_s = cnt_r - CNT_W'(1);
      default: begin
        state_s = S_INIT_WAIT;  cnt_s = CNT_W'(T_INIT - 1);
      end
    endcase

    init_done_s = init_done_r || (state_s == S_IDLE);
    if (ref_term_s) pend_s = 1'b1;
    else if (pend_clr_s) pend_s = 1'b0;
    else pend_s = pend_r;
    ready_s = (state_s == S_IDLE) && init_done_s && !pend_s;
  end

  // Control state, registered command pins, refresh timer and read-strobe pipe
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= S_INIT_WAIT;  cnt_r <= CNT_W'(T_INIT - 1);  cmd_r <= CMD_NOP;
      sa_r <= '0;  ba_r <= '0;  cke_r <= 1'b0;  ready_r <= 1'b0;  init_done_r <= 1'b0;
      wr_stb_r <= 1'b0;  pend_r <= 1'b0;  ref_cnt_r <= '0;  rd_pipe_r <= '0;
    end else begin
      state_r <= state_s;  cnt_r <= cnt_s;  cmd_r <= cmd_s;  sa_r <= sa_s;  ba_r <= ba_s;
      cke_r <= (state_s != S_INIT_WAIT);
      ready_r <= ready_s;  init_done_r <= init_done_s;  pend_r <= pend_s;
      wr_stb_r <= (cmd_s == CMD_WRITE);
      rd_pipe_r <= (rd_pipe_r << 1) | CL'(cmd_r == CMD_READ);
      if (init_done_r) ref_cnt_r <= ref_term_s ? '0 : ref_cnt_r + REF_W'(1);
    end
  end

  // Open-row table and latched request fields
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_r <= '0;  open_row_r <= '{default: '0};
      bank_r <= '0;  row_r <= '0;  col_r <= '0;  wr_r <= 1'b0;
    end else begin
      if (tbl_clr_all_s) valid_r <= '0;
      else if (tbl_set_s) begin
        valid_r[tbl_bank_s] <= 1'b1;  open_row_r[tbl_bank_s] <= tbl_row_s;
      end else if (tbl_clr_s) valid_r[tbl_bank_s] <= 1'b0;
      if (accept_s) begin
        bank_r <= req_bank_s;  row_r <= req_row_s;  col_r <= req_col_s;  wr_r <= REQ_WR;
      end
    end
  end

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_r;
  assign SA        = sa_r;
  assign BA        = ba_r;
  assign CKE       = cke_r;
  assign REQ_READY = ready_r;
  assign INIT_DONE = init_done_r;
  assign WR_STB    = wr_stb_r;
  assign RD_STB    = rd_pipe_r[CL-1];

endmodule

// File: tb/tb_ddr_sdram_bank_sched.sv
// Directed bench for ddr_sdram_bank_sched: expected commands are queued when a
// request is driven and popped as each command appears on the SDRAM pins.
module tb_ddr_sdram_bank_sched;

  localparam logic [3:0] CMD_ACT = 4'b0011, CMD_RD = 4'b0101, CMD_WR = 4'b0100,
                         CMD_PRE = 4'b0010, CMD_REF = 4'b0001, CMD_LMR = 4'b0000;
  // {CKE, CS_N, RAS_N, CAS_N, WE_N, REQ_READY, WR_STB, RD_STB, INIT_DONE, SA, BA}
  localparam logic [22:0] RST_VEC = {9'b011110000, 12'h000, 2'b00};
  localparam logic [11:0] B10 = 12'h400;

  logic        CLK, RESET_N, REQ_VALID, REQ_READY, REQ_WR;
  logic [22:0] REQ_ADDR;
  logic [11:0] SA;
  logic [1:0]  BA;
  logic        CS_N, RAS_N, CAS_N, WE_N, CKE, WR_STB, RD_STB, INIT_DONE;

  typedef struct {
    string       tag;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    bit          ba_care;
    logic [11:0] sa;
    logic [11:0] mask;
    int          gap;
    bit          exact;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   last_cyc = 0;
  int   done_cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ddr_sdram_bank_sched dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .SA(SA), .BA(BA), .CS_N(CS_N),
    .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N), .CKE(CKE), .WR_STB(WR_STB),
    .RD_STB(RD_STB), .INIT_DONE(INIT_DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] cmd, input logic [1:0] ba,
                      input bit ba_care, input logic [11:0] sa, input logic [11:0] mask,
                      input int gap, input bit exact);
    exp_t e;
    e.tag = tag;  e.cmd = cmd;  e.ba = ba;  e.ba_care = ba_care;
    e.sa = sa;  e.mask = mask;  e.gap = gap;  e.exact = exact;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the next command, compare it against the queue head, step past it
  task automatic check_next();
    exp_t e;
    int b, g;
    b = 0;
    while (CS_N !== 1'b0 && b < 100) begin
      @(negedge CLK);
      b++;
    end
    e = exp_q.pop_front();
    g = cyc - last_cyc;
    chk({e.tag, "_cmd"}, 32'({CS_N, RAS_N, CAS_N, WE_N}), 32'(e.cmd));
    if (e.ba_care) chk({e.tag, "_ba"}, 32'(BA), 32'(e.ba));
    chk({e.tag, "_sa"}, 32'(SA & e.mask), 32'(e.sa & e.mask));
    chk({e.tag, "_wrstb"}, 32'(WR_STB), 32'(e.cmd == CMD_WR));
    if (e.gap >= 0) begin
      if (e.exact) chk({e.tag, "_gap"}, 32'(g), 32'(e.gap));
      else begin
        vectors++;
        assert (g >= e.gap) else begin
          miscompares++;
          $error("FAIL %s_gap: got %0d expected >= %0d", e.tag, g, e.gap);
        end
      end
    end
    last_cyc = cyc;
    @(negedge CLK);
  endtask

  task automatic check_reset(input string tag);
    chk(tag, 32'({CKE, CS_N, RAS_N, CAS_N, WE_N, REQ_READY, WR_STB, RD_STB, INIT_DONE, SA, BA}),
        32'(RST_VEC));
  endtask

  task automatic do_init(input string tag);
    int n;
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    n = 0;
    @(negedge CLK);
    while (CKE === 1'b0 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
    chk({tag, "_cke_low"}, 32'(n), 32'd200);
    push({tag, "_pre"}, CMD_PRE, 2'd0, 1'b0, B10, B10, -1, 1'b1);
    push({tag, "_ref1"}, CMD_REF, 2'd0, 1'b0, 12'h000, 12'h000, 3, 1'b1);
    push({tag, "_ref2"}, CMD_REF, 2'd0, 1'b0, 12'h000, 12'h000, 10, 1'b1);
    push({tag, "_lmr"}, CMD_LMR, 2'd0, 1'b1, 12'h033, 12'hFFF, 10, 1'b1);
    repeat (4) check_next();
    chk({tag, "_done_early"}, 32'(INIT_DONE), 32'd0);
    @(negedge CLK);
    chk({tag, "_done"}, 32'({INIT_DONE, REQ_READY}), 32'd3);
    done_cyc = cyc;
  endtask

  task automatic issue(input logic wr, input logic [1:0] b, input logic [11:0] r,
                       input logic [8:0] c);
    int n;
    n = 0;
    while (REQ_READY !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_wait", 32'(REQ_READY), 32'd1);
    REQ_WR = wr;  REQ_ADDR = {b, r, c};  REQ_VALID = 1'b1;
    last_cyc = cyc;
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  // Called one cycle after a READ: RD_STB must pulse exactly CL cycles after it
  task automatic check_rd(input string tag);
    int rc;
    rc = last_cyc;
    while (cyc <= rc + 4) begin
      chk(tag, 32'(RD_STB), 32'(cyc == rc + 3));
      @(negedge CLK);
    end
  endtask

  initial begin
    RESET_N = 1'b0;  REQ_VALID = 1'b0;  REQ_WR = 1'b0;  REQ_ADDR = '0;
    repeat (3) @(negedge CLK);
    check_reset("reset_state");
    do_init("init");

    issue(1'b0, 2'd1, 12'd5, 9'd8);
    push("rd_closed_act", CMD_ACT, 2'd1, 1'b1, 12'd5, 12'hFFF, 1, 1'b1);
    push("rd_closed_read", CMD_RD, 2'd1, 1'b1, 12'd8, 12'hFFF, 3, 1'b1);
    repeat (2) check_next();
    check_rd("rd_closed_stb");

    issue(1'b1, 2'd1, 12'd5, 9'd20);
    push("wr_hit", CMD_WR, 2'd1, 1'b1, 12'd20, 12'hFFF, 1, 1'b1);
    check_next();
    chk("wr_stb_single", 32'(WR_STB), 32'd0);

    issue(1'b0, 2'd1, 12'd6, 9'd3);
    push("conf_pre", CMD_PRE, 2'd1, 1'b1, 12'h000, B10, 1, 1'b1);
    push("conf_act", CMD_ACT, 2'd1, 1'b1, 12'd6, 12'hFFF, 3, 1'b1);
    push("conf_read", CMD_RD, 2'd1, 1'b1, 12'd3, 12'hFFF, 3, 1'b1);
    repeat (3) check_next();
    check_rd("conf_stb");

    issue(1'b1, 2'd2, 12'hABC, 9'h1FF);
    push("b2_act", CMD_ACT, 2'd2, 1'b1, 12'hABC, 12'hFFF, 1, 1'b1);
    push("b2_write", CMD_WR, 2'd2, 1'b1, 12'h1FF, 12'hFFF, 3, 1'b1);
    repeat (2) check_next();

    issue(1'b0, 2'd2, 12'hABC, 9'h000);
    push("b2_read_hit", CMD_RD, 2'd2, 1'b1, 12'h000, 12'hFFF, 1, 1'b1);
    check_next();
    check_rd("b2_stb");

    while (cyc < done_cyc + 779) @(negedge CLK);
    chk("ref_ready_before", 32'(REQ_READY), 32'd1);
    @(negedge CLK);
    REQ_WR = 1'b0;  REQ_ADDR = {2'd1, 12'd6, 9'd9};  REQ_VALID = 1'b1;
    chk("ref_ready_blocked", 32'(REQ_READY), 32'd0);
    last_cyc = cyc;
    push("ref_pre_all", CMD_PRE, 2'd0, 1'b0, B10, B10, 1, 1'b1);
    push("ref_ref", CMD_REF, 2'd0, 1'b0, 12'h000, 12'h000, 3, 1'b1);
    push("ref_fresh_act", CMD_ACT, 2'd1, 1'b1, 12'd6, 12'hFFF, 10, 1'b0);
    push("ref_read", CMD_RD, 2'd1, 1'b1, 12'd9, 12'hFFF, 3, 1'b1);
    repeat (3) check_next();
    REQ_VALID = 1'b0;
    check_next();
    check_rd("ref_stb");

    issue(1'b0, 2'd3, 12'd1, 9'd2);
    push("mid_act", CMD_ACT, 2'd3, 1'b1, 12'd1, 12'hFFF, 1, 1'b1);
    check_next();
    #2 RESET_N = 1'b0;
    #1 check_reset("reset_mid_rcd");
    repeat (2) @(negedge CLK);
    check_reset("reset_held");
    do_init("reinit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_sdram_bank_sched.md
DDR_SDRAM_BANK_SCHED -- requirements
Module: ddr_sdram_bank_sched

Interface
REQ-001 SHALL have parameters: ROW_W 12 (row bits); COL_W 9 (column bits); BANK_W 2 (bank bits, 2^BANK_W banks); T_INIT 200 (power-up wait cycles); T_RP 3; T_RCD 3; T_RFC 10; T_GAP 4 (cycles after READ/WRITE before next command); CL 3 (read latency); REF_INT 780 (refresh period); MODE_REG 12'h033 (LOAD MODE value).
REQ-002 SHALL have ports, in this order:
  CLK  in  1  controller clock, all logic rising-edge.
  RESET_N  in  1  asynchronous, active-low reset.
  REQ_VALID  in  1  request present.
  REQ_READY  out  1  request accepted when high with REQ_VALID.
  REQ_WR  in  1  1=write, 0=read.
  REQ_ADDR  in  BANK_W+ROW_W+COL_W  {bank,row,col}, bank MSBs.
  SA  out  ROW_W  SDRAM address.
  BA  out  BANK_W  SDRAM bank.
  CS_N, RAS_N, CAS_N, WE_N, CKE  out  1 each  SDRAM control.
  WR_STB  out  1  one-cycle pulse on WRITE issue.
  RD_STB  out  1  one-cycle pulse CL cycles after READ issue.
  INIT_DONE  out  1  high once init complete.
REQ-003 Reset SHALL be asynchronous and active-low on RESET_N; the single clock is CLK. ROW_W SHALL be at least COL_W+2.

Function
REQ-004 Commands {RAS_N,CAS_N,WE_N} with CS_N=0: ACT 011, READ 101, WRITE 100, PRE 010, REF 001, LMR 000; idle cycles SHALL drive CS_N=1, 111.
REQ-005 All command outputs SHALL be registered; each command lasts exactly one cycle.
REQ-006 Init: CKE=0 for T_INIT cycles, then CKE=1, PRE with SA[10]=1, wait T_RP, REF, wait T_RFC, REF, wait T_RFC, LMR with SA=MODE_REG, BA=0, wait 2, then INIT_DONE=1 and IDLE.
REQ-007 Open-row table: per bank a valid bit and ROW_W row; all invalid after init and after refresh.
REQ-008 REQ_READY SHALL be 1 only in IDLE with INIT_DONE=1 and no refresh pending; request fields latched on accept.
REQ-009 Hit (bank valid, row equal): READ/WRITE issued the cycle after accept.
REQ-010 Closed bank: ACT (BA=bank, SA=row), T_RCD wait, then READ/WRITE; table entry set on ACT.
REQ-011 Conflict (bank valid, row differs): PRE with SA[10]=0 to that bank, T_RP wait, then as REQ-010.
REQ-012 READ/WRITE: BA=bank, SA[COL_W-1:0]=col, SA[10]=0 (no auto-precharge), other SA bits 0; row stays open.
REQ-013 After READ/WRITE, T_GAP cycles before returning to IDLE.
REQ-014 RD_STB SHALL come from a CL-deep shift register; back-to-back reads produce distinct pulses.
REQ-015 Refresh counter counts 0..REF_INT-1 from INIT_DONE, wraps, sets refresh pending at terminal count; pending saturates (no queuing of multiple).
REQ-016 Pending refresh SHALL be served when IDLE, taking priority over REQ_VALID in the same cycle: PRE-all (SA[10]=1) only if any bank valid, T_RP wait, REF, T_RFC wait, clear table and pending.
REQ-017 Wait counters SHALL load value-1 so wait length equals the parameter exactly.
REQ-018 States: INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_LMR, IDLE, PRE, ACT, RW, GAP, REF_PRE, REF; waits handled by a shared down-counter.

Reset
REQ-019 On RESET_N low, at any time including mid-operation: state INIT_WAIT, CKE=0, CS_N=1, RAS_N=CAS_N=WE_N=1, SA=0, BA=0, REQ_READY=0, WR_STB=RD_STB=0, INIT_DONE=0, table cleared, refresh counter 0, CL pipe cleared.

Verification
REQ-020 Release reset -> CKE=0 for 200 cycles, then PRE(SA[10]=1), REF, REF, LMR SA=12'h033 at the correct spacings; INIT_DONE=1.
REQ-021 Read bank 1 row 5 col 8 on a closed bank -> ACT BA=1 SA=5, READ 3 cycles later SA=8, RD_STB 3 cycles after READ.
REQ-022 Write same bank and row -> WRITE next cycle after accept, no ACT, WR_STB coincident with WRITE.
REQ-023 Read bank 1 row 6 -> PRE BA=1 SA[10]=0, ACT 3 cycles later SA=6, READ 3 after that.
REQ-024 Refresh pending collides with REQ_VALID in IDLE -> REQ_READY=0, PRE-all, REF 3 cycles later, request served after T_RFC with fresh ACT.
REQ-025 Assert RESET_N low during an RCD wait -> all outputs at REQ-019 values immediately; init sequence restarts on release.
